sum_display_driver: RTL and testbench

//  Output-side consumer of the accumulator's 13-bit sum. Sequentially converts the binary sum to
//  4 BCD digits (shift-add-3, one bit per clock) and drives a 4-digit multiplexed 7-segment display.

---
 rtl/sum_display_driver_if.sv | 30 +++
 rtl/sum_display_driver.sv | 205 ++++++++++++++++++++
 tb/tb_sum_display_driver.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/sum_display_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : sum_display_driver_if
// Description : Bundle between the accumulator side (value in) and the
//               display driver (BCD result, status and 7-segment pins).
// Revision    : 1.0 - initial release
// ============================================================================
interface sum_display_driver_if #(
  parameter int WIDTH = 13
);
  logic [WIDTH-1:0] value;
  logic             busy;
  logic [15:0]      bcd;
  logic             bcd_valid;
  logic [6:0]       seg;
  logic [3:0]       an;

  // Producer of the binary value / consumer of the display outputs
  modport master (
    output value,
    input  busy, bcd, bcd_valid, seg, an
  );

  // The display driver itself
  modport slave (
    input  value,
    output busy, bcd, bcd_valid, seg, an
  );
endinterface
`default_nettype wire

// File: rtl/sum_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : sum_display_driver
// Description : Sequential binary-to-BCD converter (shift-add-3, one bit per
//               clock) driving a 4-digit multiplexed active-low 7-segment
//               display. Re-converts whenever the input value changes.
// Revision    : 1.0 - initial release
// ============================================================================
module sum_display_driver #(
  parameter int WIDTH       = 13,
  parameter int REFRESH_DIV = 27000,
  parameter bit BLANK_LEAD  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  sum_display_driver_if.slave  bus
);

  localparam int                BCNT_W    = $clog2(WIDTH + 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WIDTH - 1);
  localparam int                RCNT_W    = $clog2(REFRESH_DIV);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REFRESH_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD nibble
  function automatic logic [6:0] f_seg(input logic [3:0] nib);
    case (nib)
      4'd0:    f_seg = 7'b1000000;
      4'd1:    f_seg = 7'b1111001;
      4'd2:    f_seg = 7'b0100100;
      4'd3:    f_seg = 7'b0110000;
      4'd4:    f_seg = 7'b0011001;
      4'd5:    f_seg = 7'b0010010;
      4'd6:    f_seg = 7'b0000010;
      4'd7:    f_seg = 7'b1111000;
      4'd8:    f_seg = 7'b0000000;
      4'd9:    f_seg = 7'b0010000;
      default: f_seg = 7'b0111111;
    endcase
  endfunction

  // ---------------------------------------------------------------- state
  logic [1:0]        state_q, state_d;
  logic              w_start, w_load, w_shift_en, w_commit, w_busy;

  // ------------------------------------------------------------ datapath
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [15:0]       scratch_q, scratch_d;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]  last_value_q, last_value_d;
  logic              force_q, force_d;
  logic [15:0]       bcd_q, bcd_d;
  logic              bcd_valid_q, bcd_valid_d;
  logic [15:0]       w_adj;
  logic [16+WIDTH-1:0] w_shifted;

  // ------------------------------------------------------------- display
  logic [RCNT_W-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]        digit_idx_q, digit_idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [3:0]        an_q, an_d;
  logic [3:0][3:0]   w_digits;
  logic [3:0]        w_lz;
  logic [3:0]        w_nibble;
  logic              w_blank;

  // A new conversion is wanted when the input moved or after reset
  assign w_start = (bus.value != last_value_q) || force_q;

  // Conversion FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Conversion FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_start) state_d = S_SHIFT;
      S_SHIFT: if (bit_cnt_q == BCNT_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Conversion FSM outputs: datapath strobes and busy flag
  always_comb begin
    w_load     = 1'b0;
    w_shift_en = 1'b0;
    w_commit   = 1'b0;
    w_busy     = 1'b0;
    case (state_q)
      S_IDLE:  w_load = w_start;
      S_SHIFT: begin w_shift_en = 1'b1; w_busy = 1'b1; end
      S_DONE:  begin w_commit   = 1'b1; w_busy = 1'b1; end
      default: ;
    endcase
  end

  // Add-3 correction of each scratch nibble before it is shifted
  for (genvar gi = 0; gi < 4; gi++) begin : g_adj
    assign w_adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5) ?
                              scratch_q[gi*4 +: 4] + 4'd3 : scratch_q[gi*4 +: 4];
  end

  assign w_shifted = {w_adj, shift_q} << 1;

  // Datapath next-state: capture, shift-add-3 step, commit of the result
  always_comb begin
    shift_d      = shift_q;
    scratch_d    = scratch_q;
    bit_cnt_d    = bit_cnt_q;
    last_value_d = last_value_q;
    force_d      = force_q;
    bcd_d        = bcd_q;
    bcd_valid_d  = w_commit;
    if (w_load) begin
      shift_d      = bus.value;
      last_value_d = bus.value;
      scratch_d    = '0;
      bit_cnt_d    = '0;
      force_d      = 1'b0;
    end
    if (w_shift_en) begin
      scratch_d = w_shifted[16+WIDTH-1:WIDTH];
      shift_d   = w_shifted[WIDTH-1:0];
      bit_cnt_d = bit_cnt_q + BCNT_W'(1);
    end
    if (w_commit) bcd_d = scratch_q;
  end

  // Datapath registers; reset forces a fresh conversion afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q      <= '0;
      scratch_q    <= '0;
      bit_cnt_q    <= '0;
      last_value_q <= '0;
      force_q      <= 1'b1;
      bcd_q        <= '0;
      bcd_valid_q  <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      scratch_q    <= scratch_d;
      bit_cnt_q    <= bit_cnt_d;
      last_value_q <= last_value_d;
      force_q      <= force_d;
      bcd_q        <= bcd_d;
      bcd_valid_q  <= bcd_valid_d;
    end
  end

  // Leading-zero chain: w_lz[i] is set when nibbles i..3 are all zero
  assign w_digits = bcd_q;
  for (genvar gd = 0; gd < 4; gd++) begin : g_lz
    if (gd == 3) begin : g_top
      assign w_lz[gd] = (w_digits[gd] == 4'd0);
    end else begin : g_low
      assign w_lz[gd] = (w_digits[gd] == 4'd0) && w_lz[gd+1];
    end
  end

  // Refresh timing and segment/anode selection for the upcoming digit slot;
  // seg and an are both derived from the next index so they switch together
  always_comb begin
    if (refresh_cnt_q == RCNT_LAST) begin
      refresh_cnt_d = '0;
      digit_idx_d   = digit_idx_q + 2'd1;
    end else begin
      refresh_cnt_d = refresh_cnt_q + RCNT_W'(1);
      digit_idx_d   = digit_idx_q;
    end
    w_nibble = w_digits[digit_idx_d];
    w_blank  = BLANK_LEAD && (digit_idx_d != 2'd0) && w_lz[digit_idx_d];
    seg_d    = w_blank ? 7'b1111111 : f_seg(w_nibble);
    an_d     = ~(4'b0001 << digit_idx_d);
  end

  // Display registers, free-running and independent of the converter
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_q <= '0;
      digit_idx_q   <= 2'd0;
      seg_q         <= 7'b1000000;
      an_q          <= 4'b1110;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      digit_idx_q   <= digit_idx_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  assign bus.busy      = w_busy;
  assign bus.bcd       = bcd_q;
  assign bus.bcd_valid = bcd_valid_q;
  assign bus.seg       = seg_q;
  assign bus.an        = an_q;

endmodule
`default_nettype wire

// File: tb/tb_sum_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_display_driver
// Description : Self-checking bench for sum_display_driver (REFRESH_DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_display_driver;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;

  typedef struct {
    logic [12:0]     value;
    logic [15:0]     bcd;
    logic [3:0][6:0] seg;   // seg[0] = units digit
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  sum_display_driver_if #(.WIDTH(13)) bus ();

  sum_display_driver #(
    .WIDTH      (13),
    .REFRESH_DIV(4),
    .BLANK_LEAD (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Apply a value and watch 25 cycles: first bcd_valid tick, pulse count, busy cycles
  task automatic run_conv(input logic [12:0] v, output int vtick, output int npulse,
                          output int nbusy, output logic [15:0] got);
    bus.value = v;
    vtick = -1; npulse = 0; nbusy = 0; got = 16'hFFFF;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (bus.busy) nbusy++;
      if (bus.bcd_valid) begin
        npulse++;
        if (vtick < 0) begin
          vtick = k;
          got   = bus.bcd;
        end
      end
    end
  endtask

  // Observe 16 cycles and record the pattern shown in each digit slot
  task automatic scan_digits(output logic [3:0][6:0] segs, output int bad_an);
    segs = '1; bad_an = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      case (bus.an)
        4'b1110: segs[0] = bus.seg;
        4'b1101: segs[1] = bus.seg;
        4'b1011: segs[2] = bus.seg;
        4'b0111: segs[3] = bus.seg;
        default: bad_an++;
      endcase
    end
  endtask

  function automatic vec_t mk(input logic [12:0] v, input logic [15:0] b,
                              input logic [6:0] d3, input logic [6:0] d2,
                              input logic [6:0] d1, input logic [6:0] d0);
    vec_t r;
    r.value = v;
    r.bcd   = b;
    r.seg   = {d3, d2, d1, d0};
    return r;
  endfunction

  initial begin
    vec_t            vecs [7];
    int              vtick, npulse, nbusy, bad_an;
    logic [15:0]     got;
    logic [3:0][6:0] segs;
    int              p_tick [4];
    logic [15:0]     p_bcd  [4];
    logic [3:0]      exp_an;
    logic [6:0]      exp_seg;

    vecs[0] = mk(13'd1234, 16'h1234, S1, S2, S3, S4);
    vecs[1] = mk(13'd8191, 16'h8191, S8, S1, S9, S1);
    vecs[2] = mk(13'd4096, 16'h4096, S4, S0, S9, S6);
    vecs[3] = mk(13'd10,   16'h0010, SB, SB, S1, S0);
    vecs[4] = mk(13'd7,    16'h0007, SB, SB, SB, S7);
    vecs[5] = mk(13'd505,  16'h0505, SB, S5, S0, S5);
    vecs[6] = mk(13'd0,    16'h0000, SB, SB, SB, S0);

    // ---- reset state with value=0
    rst = 1'b1;
    bus.value = '0;
    tick(); tick(); tick();
    chk("reset_busy",  {31'd0, bus.busy},      32'd0);
    chk("reset_bcd",   {16'd0, bus.bcd},       32'd0);
    chk("reset_valid", {31'd0, bus.bcd_valid}, 32'd0);
    chk("reset_an",    {28'd0, bus.an},        32'hE);
    chk("reset_seg",   {25'd0, bus.seg},       {25'd0, S0});

    // ---- release: forced conversion of 0, anode rotation every 4 clocks
    rst = 1'b0;
    vtick = -1; npulse = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_an  = ~(4'b0001 << ((k / 4) % 4));
      exp_seg = (exp_an == 4'b1110) ? S0 : SB;
      chk("rot_an",  {28'd0, bus.an},  {28'd0, exp_an});
      chk("rot_seg", {25'd0, bus.seg}, {25'd0, exp_seg});
      if (bus.bcd_valid) begin
        npulse++;
        if (vtick < 0) begin vtick = k; got = bus.bcd; end
      end
    end
    chk("init_valid_tick", vtick,  32'd15);
    chk("init_pulses",     npulse, 32'd1);
    chk("init_bcd",        {16'd0, got}, 32'd0);

    // ---- table of conversions and digit contents
    for (int i = 0; i < 7; i++) begin
      run_conv(vecs[i].value, vtick, npulse, nbusy, got);
      chk("conv_valid_tick", vtick,  32'd15);
      chk("conv_pulses",     npulse, 32'd1);
      chk("conv_busy_len",   nbusy,  32'd14);
      chk("conv_bcd",        {16'd0, got}, {16'd0, vecs[i].bcd});
      scan_digits(segs, bad_an);
      chk("scan_an_onehot", bad_an, 32'd0);
      for (int d = 0; d < 4; d++)
        chk("digit_seg", {25'd0, segs[d]}, {25'd0, vecs[i].seg[d]});
    end

    // ---- value change while busy: skipped mid-conversion, caught in IDLE
    bus.value = 13'd100;
    npulse = 0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (k == 5) bus.value = 13'd200;
      if (bus.bcd_valid) begin
        if (npulse < 4) begin
          p_tick[npulse] = k;
          p_bcd[npulse]  = bus.bcd;
        end
        npulse++;
      end
    end
    chk("chg_pulses", npulse, 32'd2);
    if (npulse >= 2) begin
      chk("chg_tick1", p_tick[0], 32'd15);
      chk("chg_bcd1",  {16'd0, p_bcd[0]}, 32'h0100);
      chk("chg_tick2", p_tick[1], 32'd30);
      chk("chg_bcd2",  {16'd0, p_bcd[1]}, 32'h0200);
    end

    // ---- reset in the middle of a conversion
    bus.value = 13'd555;
    for (int k = 0; k < 6; k++) tick();
    chk("mid_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    tick();
    chk("abort_busy",  {31'd0, bus.busy},      32'd0);
    chk("abort_bcd",   {16'd0, bus.bcd},       32'd0);
    chk("abort_valid", {31'd0, bus.bcd_valid}, 32'd0);
    tick();
    chk("abort_valid2", {31'd0, bus.bcd_valid}, 32'd0);
    rst = 1'b0;
    run_conv(13'd555, vtick, npulse, nbusy, got);
    chk("rerun_valid_tick", vtick,  32'd15);
    chk("rerun_pulses",     npulse, 32'd1);
    chk("rerun_bcd",        {16'd0, got}, 32'h0555);

    // ---- steady input: no further activity
    npulse = 0; nbusy = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (bus.bcd_valid) npulse++;
      if (bus.busy)      nbusy++;
    end
    chk("idle_pulses", npulse, 32'd0);
    chk("idle_busy",   nbusy,  32'd0);
    chk("idle_bcd",    {16'd0, bus.bcd}, 32'h0555);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
